led_sequencer: RTL

//  Parametrised board LED pattern generator; next generation of the free-running counter blinker.
//  A prescaler produces a slow step tick; a selectable pattern engine (binary count, bouncing scan,

---
 rtl/led_sequencer_pkg.sv | 16 +
 rtl/led_sequencer_tick_gen.sv | 33 +++
 rtl/led_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED pattern blocks: pattern modes and sweep direction.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// Enable-gated prescaler producing a registered one-cycle step strobe.
// o_step is the combinational "this edge is a step edge" qualifier; o_tick is
// the same event registered, so it is high in the cycle right after that edge.
module tick_gen #(
  parameter int PRESCALE_WIDTH = 22
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_step,
  output logic o_tick
);

  logic [PRESCALE_WIDTH-1:0] r_prescaler;
  logic                      r_tick;

  assign o_step = i_enable && (r_prescaler == '1);
  assign o_tick = r_tick;

  // Prescaler advances only on enabled cycles; strobe follows the wrap edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prescaler <= '0;
      r_tick      <= 1'b0;
    end else begin
      if (i_enable) begin
        r_prescaler <= r_prescaler + PRESCALE_WIDTH'(1);
      end
      r_tick <= o_step;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Board LED pattern generator: prescaled step tick drives one of four pattern
// engines (binary count, bouncing scan, blink, PWM breathe) onto NLEDS outputs.
// In the non-breathe modes the LED register itself holds the pattern state.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int NLEDS          = 4,
  parameter int PRESCALE_WIDTH = 22,
  parameter int PWM_BITS       = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  output logic [NLEDS-1:0] o_led,
  output logic             o_tick
);

  localparam logic [NLEDS-1:0]    PATTERN_ONE = NLEDS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX    = '1;

  logic                w_step;
  logic                w_mode_change;
  mode_e               w_mode_req;

  mode_e               r_mode;
  dir_e                r_dir;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [NLEDS-1:0]    r_led;

  mode_e               w_mode_next;
  dir_e                w_dir_next;
  logic [PWM_BITS-1:0] w_duty_next;
  logic [NLEDS-1:0]    w_pattern_next;

  tick_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_tick_gen (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .o_step   (w_step),
    .o_tick   (o_tick)
  );

  assign w_mode_req    = mode_e'(i_mode);
  assign w_mode_change = w_step && (w_mode_req != r_mode);
  assign o_led         = r_led;

  // Next pattern state: load the new mode's start value on a mode change, else advance one step.
  always_comb begin
    w_mode_next    = r_mode;
    w_dir_next     = r_dir;
    w_duty_next    = r_duty;
    w_pattern_next = r_led;
    if (w_mode_change) begin
      w_mode_next = w_mode_req;
      w_dir_next  = DIR_UP;
      w_duty_next = '0;
      case (w_mode_req)
        MODE_COUNT: w_pattern_next = '0;
        MODE_SCAN:  w_pattern_next = PATTERN_ONE;
        MODE_BLINK: w_pattern_next = '1;
        default:    w_pattern_next = '0;  // breathe starts dark at duty 0
      endcase
    end else if (w_step) begin
      case (r_mode)
        MODE_COUNT: w_pattern_next = r_led + NLEDS'(1);
        MODE_SCAN: begin
          // End LEDs dwell for a single step: flip direction while stepping off the end.
          if (NLEDS == 1) begin
            w_pattern_next = PATTERN_ONE;
          end else if (r_dir == DIR_UP) begin
            if (r_led[NLEDS-1]) begin
              w_pattern_next = r_led >> 1;
              w_dir_next     = DIR_DOWN;
            end else begin
              w_pattern_next = r_led << 1;
            end
          end else begin
            if (r_led[0]) begin
              w_pattern_next = r_led << 1;
              w_dir_next     = DIR_UP;
            end else begin
              w_pattern_next = r_led >> 1;
            end
          end
        end
        MODE_BLINK: w_pattern_next = ~r_led;
        default: begin
          // Triangle duty sweep, reversing on the step that leaves either end.
          if (r_dir == DIR_UP) begin
            if (r_duty == DUTY_MAX) begin
              w_duty_next = r_duty - PWM_BITS'(1);
              w_dir_next  = DIR_DOWN;
            end else begin
              w_duty_next = r_duty + PWM_BITS'(1);
            end
          end else begin
            if (r_duty == '0) begin
              w_duty_next = r_duty + PWM_BITS'(1);
              w_dir_next  = DIR_UP;
            end else begin
              w_duty_next = r_duty - PWM_BITS'(1);
            end
          end
        end
      endcase
    end
  end

  // Pattern/PWM state register; every bit holds while disabled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode    <= MODE_COUNT;
      r_dir     <= DIR_UP;
      r_duty    <= '0;
      r_pwm_cnt <= '0;
      r_led     <= '0;
    end else if (i_enable) begin
      r_mode    <= w_mode_next;
      r_dir     <= w_dir_next;
      r_duty    <= w_duty_next;
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (w_mode_next == MODE_BREATHE && !w_mode_change) begin
        r_led <= {NLEDS{r_pwm_cnt < r_duty}};
      end else begin
        r_led <= w_pattern_next;
      end
    end
  end

endmodule
